// File: rtl/cache_dir_array.sv
// Direct-mapped cache directory: one {tag, line state} entry per set, answered
// combinationally over cache_dir_if, with a clear sweep after reset or flush.
package cache_dir_pkg;
  typedef enum logic [1:0] {
    INVALID   = 2'd0,
    SHARED    = 2'd1,
    EXCLUSIVE = 2'd2,
    MODIFIED  = 2'd3
  } line_state_t;
endpackage

interface cache_dir_if #(
  parameter int ADDR_WIDTH = 32
);
  import cache_dir_pkg::*;
  logic [ADDR_WIDTH-1:0] addr;
  line_state_t           next_state;
  logic                  write;
  line_state_t           current_state;
  logic                  hit;

  modport rsp (input addr, next_state, write, output current_state, hit);
  modport req (output addr, next_state, write, input current_state, hit);
endinterface

module cache_dir_array
  import cache_dir_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 64,
  parameter int NUM_SETS   = 64
) (
  input  logic        clk,
  input  logic        rst,
  cache_dir_if.rsp    dir_if,
  input  logic        flush,
  output logic        ready,
  output line_state_t victim_state,
  output logic [ADDR_WIDTH-$clog2(NUM_SETS)-$clog2(LINE_BYTES)-1:0] victim_tag
);
  localparam int OFF = $clog2(LINE_BYTES);
  localparam int IDX = $clog2(NUM_SETS);
  localparam int TAG = ADDR_WIDTH - IDX - OFF;

  localparam logic [0:0] INIT  = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]     state_r;
  logic [IDX-1:0] clr_cnt_r;

  logic [IDX-1:0] index_s;
  logic [TAG-1:0] tag_s;
  logic           unused_off_s;

  logic           we_s;
  logic [IDX-1:0] waddr_s;
  logic [TAG-1:0] wtag_s;
  line_state_t    wstate_s;

  logic [TAG-1:0] rd_tag_s;
  line_state_t    rd_state_s;

  // No reset on the storage so it maps onto a RAM; the sweep is what clears it.
  logic [TAG-1:0] tag_mem   [NUM_SETS];
  line_state_t    state_mem [NUM_SETS];

  assign index_s      = dir_if.addr[OFF +: IDX];
  assign tag_s        = dir_if.addr[ADDR_WIDTH-1 -: TAG];
  assign unused_off_s = ^dir_if.addr[OFF-1:0];
  assign rd_tag_s     = tag_mem[index_s];
  assign rd_state_s   = state_mem[index_s];
  assign ready        = (state_r == READY);

  // Sweep/ready sequencing; flush in either state restarts the sweep at set 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= INIT;
      clr_cnt_r <= {IDX{1'b0}};
    end else begin
      case (state_r)
        INIT: begin
          if (flush) begin
            clr_cnt_r <= {IDX{1'b0}};
          end else if (clr_cnt_r == IDX'(NUM_SETS - 1)) begin
            state_r   <= READY;
            clr_cnt_r <= {IDX{1'b0}};
          end else begin
            clr_cnt_r <= clr_cnt_r + IDX'(1);
          end
        end
        READY: begin
          if (flush) begin
            state_r   <= INIT;
            clr_cnt_r <= {IDX{1'b0}};
          end
        end
        default: begin
          state_r   <= INIT;
          clr_cnt_r <= {IDX{1'b0}};
        end
      endcase
    end
  end

  // Write port select: sweep clears in INIT, requester writes in READY unless flushed.
  always_comb begin
    we_s     = 1'b0;
    waddr_s  = index_s;
    wtag_s   = tag_s;
    wstate_s = dir_if.next_state;
    if (rst) begin
      we_s = 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          we_s     = 1'b1;
          waddr_s  = clr_cnt_r;
          wtag_s   = {TAG{1'b0}};
          wstate_s = INVALID;
        end
        READY: begin
          we_s = dir_if.write && !flush;
        end
        default: begin
          we_s = 1'b0;
        end
      endcase
    end
  end

  // Synchronous storage write.
  always_ff @(posedge clk) begin
    if (we_s) begin
      tag_mem[waddr_s]   <= wtag_s;
      state_mem[waddr_s] <= wstate_s;
    end
  end

  // Lookup outputs, forced to the idle encoding until the sweep has finished.
  always_comb begin
    dir_if.hit           = 1'b0;
    dir_if.current_state = INVALID;
    victim_state         = INVALID;
    victim_tag           = {TAG{1'b0}};
    if (state_r == READY) begin
      victim_state = rd_state_s;
      victim_tag   = rd_tag_s;
      if ((rd_tag_s == tag_s) && (rd_state_s != INVALID)) begin
        dir_if.hit           = 1'b1;
        dir_if.current_state = rd_state_s;
      end else begin
        dir_if.hit           = 1'b0;
        dir_if.current_state = INVALID;
      end
    end else begin
      dir_if.hit           = 1'b0;
      dir_if.current_state = INVALID;
    end
  end
endmodule

// File: tb/tb_cache_dir_array.sv
// Directed bench for cache_dir_array: sweep timing, lookup/write behaviour,
// flush and reset interaction, with hand-computed expectations.
module tb_cache_dir_array;
  import cache_dir_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ready;
  line_state_t victim_state;
  logic [19:0] victim_tag;

  int checks = 0;
  int errors = 0;
  int rise;
  int n;
  logic any_hit;

  cache_dir_if #(.ADDR_WIDTH(32)) dif ();

  cache_dir_array #(
    .ADDR_WIDTH(32),
    .LINE_BYTES(64),
    .NUM_SETS  (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dir_if      (dif),
    .flush       (flush),
    .ready       (ready),
    .victim_state(victim_state),
    .victim_tag  (victim_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] a);
    dif.addr  = a;
    dif.write = 1'b0;
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input line_state_t s);
    dif.addr       = a;
    dif.next_state = s;
    dif.write      = 1'b1;
    tick;
    dif.write = 1'b0;
    #1;
  endtask

  // Counts sampled cycles with ready low; optionally re-pulses flush at sample k.
  task automatic wait_ready(output int cnt, input int reflush_at);
    cnt = 0;
    while (!ready && cnt < 300) begin
      cnt++;
      flush = (cnt == reflush_at);
      tick;
    end
    flush = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    dif.addr       = 32'h0001_2340;
    dif.next_state = MODIFIED;
    dif.write      = 1'b1;
    repeat (2) tick;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_hit", {31'd0, dif.hit}, 32'd0);
    chk("rst_cur", {30'd0, dif.current_state}, 32'd0);
    chk("rst_vtag", {12'd0, victim_tag}, 32'd0);
    chk("rst_vstate", {30'd0, victim_state}, 32'd0);

    // Sweep after reset, with write held high the whole time.
    rst     = 1'b0;
    rise    = 0;
    any_hit = 1'b0;
    for (int c = 1; c <= 100 && rise == 0; c++) begin
      dif.addr = 32'h0001_2340 ^ (32'(c) << 6);
      tick;
      if (dif.hit) any_hit = 1'b1;
      if (ready) rise = c;
    end
    dif.write = 1'b0;
    chk("init_rise_cycle", 32'(rise), 32'd64);
    chk("init_no_hit", {31'd0, any_hit}, 32'd0);
    lookup(32'h0001_2340);
    chk("post_init_hit", {31'd0, dif.hit}, 32'd0);
    chk("post_init_vstate", {30'd0, victim_state}, 32'd0);
    tick;

    // Set 13, tag 0x00012: same-cycle shows old contents, next cycle the new.
    dif.addr       = 32'h0001_2340;
    dif.next_state = MODIFIED;
    dif.write      = 1'b1;
    #1;
    chk("same_cycle_hit", {31'd0, dif.hit}, 32'd0);
    chk("same_cycle_vstate", {30'd0, victim_state}, 32'd0);
    tick;
    dif.write = 1'b0;
    #1;
    chk("wr_hit", {31'd0, dif.hit}, 32'd1);
    chk("wr_cur", {30'd0, dif.current_state}, 32'd3);
    lookup(32'h0002_2340);
    chk("miss_hit", {31'd0, dif.hit}, 32'd0);
    chk("miss_cur", {30'd0, dif.current_state}, 32'd0);
    chk("miss_vtag", {12'd0, victim_tag}, 32'h0000_0012);
    chk("miss_vstate", {30'd0, victim_state}, 32'd3);
    tick;

    // Invalidate keeps the tag but never hits.
    do_write(32'h0001_2340, INVALID);
    chk("inv_hit", {31'd0, dif.hit}, 32'd0);
    chk("inv_vtag", {12'd0, victim_tag}, 32'h0000_0012);
    chk("inv_vstate", {30'd0, victim_state}, 32'd0);

    // Fill sets 0, 5 (back-to-back) and 63.
    do_write(32'h0000_3000, SHARED);
    do_write(32'h0000_1140, SHARED);
    do_write(32'h0000_1140, EXCLUSIVE);
    do_write(32'hABCD_EFC0, EXCLUSIVE);
    lookup(32'h0000_1140);
    chk("b2b_last_wins", {30'd0, dif.current_state}, 32'd2);
    tick;
    lookup(32'h0000_3000);
    chk("set0_hit", {31'd0, dif.hit}, 32'd1);
    tick;
    lookup(32'hABCD_EFC0);
    chk("set63_hit", {31'd0, dif.hit}, 32'd1);
    chk("set63_vtag", {12'd0, victim_tag}, 32'h000A_BCDE);
    tick;

    // Flush together with a write to set 0 (tag 4): write dropped, 64-cycle sweep.
    dif.addr       = 32'h0000_4000;
    dif.next_state = MODIFIED;
    dif.write      = 1'b1;
    flush          = 1'b1;
    tick;
    flush     = 1'b0;
    dif.write = 1'b0;
    wait_ready(n, 0);
    chk("flush_low_cycles", 32'(n), 32'd64);
    lookup(32'h0000_4000);
    chk("flush_set0_hit", {31'd0, dif.hit}, 32'd0);
    chk("flush_set0_vtag", {12'd0, victim_tag}, 32'd0);
    chk("flush_set0_vstate", {30'd0, victim_state}, 32'd0);
    tick;
    lookup(32'h0000_1140);
    chk("flush_set5_vstate", {30'd0, victim_state}, 32'd0);
    tick;
    lookup(32'hABCD_EFC0);
    chk("flush_set63_hit", {31'd0, dif.hit}, 32'd0);
    chk("flush_set63_vtag", {12'd0, victim_tag}, 32'd0);
    tick;

    // Second flush partway through the sweep extends ready-low to 30+64 cycles.
    flush = 1'b1;
    tick;
    flush = 1'b0;
    wait_ready(n, 30);
    chk("reflush_low_cycles", 32'(n), 32'd94);

    // Reset during a write to set 7.
    do_write(32'h0000_51C0, SHARED);
    chk("set7_hit", {31'd0, dif.hit}, 32'd1);
    tick;
    dif.addr       = 32'h0000_61C0;
    dif.next_state = MODIFIED;
    dif.write      = 1'b1;
    rst            = 1'b1;
    #1;
    chk("rst_mid_ready", {31'd0, ready}, 32'd0);
    tick;
    rst       = 1'b0;
    dif.write = 1'b0;
    wait_ready(n, 0);
    chk("rst_mid_low_cycles", 32'(n), 32'd64);
    lookup(32'h0000_61C0);
    chk("rst_set7_new_hit", {31'd0, dif.hit}, 32'd0);
    chk("rst_set7_vstate", {30'd0, victim_state}, 32'd0);
    tick;
    lookup(32'h0000_51C0);
    chk("rst_set7_old_hit", {31'd0, dif.hit}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
